// File: rtl/arith_unit_if.sv
// arith_unit_if - start/done handshake and result bus of arith_unit.
//
// Parameter:
//   WIDTH      operand/result width in bits (>= 2)
// Signals:
//   start, op, a, b                      request side (driven by master)
//   busy, done, result, result_hi,
//   overflow, carry, zero, negative      completion side (driven by slave)
// Modports:
//   master  command source (UART command decoder / testbench)
//   slave   arith_unit
interface arith_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             overflow;
    logic             carry;
    logic             zero;
    logic             negative;

    modport master (
        output start, op, a, b,
        input  busy, done, result, result_hi, overflow, carry, zero, negative
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, result_hi, overflow, carry, zero, negative
    );
endinterface

// File: rtl/arith_unit.sv
// arith_unit - sequential add/subtract/add-with-carry/multiply unit.
//
// ADD, SUB and ADC finish on the edge that accepts start. MUL is an unsigned
// shift-add multiplier taking WIDTH steps after acceptance. All results and
// flags are registered and hold until the next completion or reset.
//
// Configuration macro:
//   ARITH_MUL_EN  when defined, the multiplier (MUL state, step counter and
//                 accumulator) is built. When undefined, op = MUL completes
//                 in one cycle with zero result and all flags cleared.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    arith_unit_if slave modport (start/op/a/b in, results/flags out)
module arith_unit #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    arith_unit_if.slave  bus
);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ADC = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             overflow_q, overflow_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;

    // Adder datapath shared by ADD, SUB and ADC.
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_s;
    logic [WIDTH:0]   sum_ext_s;
    logic [WIDTH-1:0] sum_s;

`ifdef ARITH_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    // prod_q holds {partial high word, remaining multiplier bits}; the low
    // half shifts out the multiplier while the product shifts in from above.
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     step_sum_s;
    logic [2*WIDTH-1:0] step_prod_s;
`endif

    // Next-state and next-output computation for both states.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        overflow_d  = overflow_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        negative_d  = negative_q;

        // SUB is a + ~b + 1; ADC feeds back the carry of the previous op.
        b_eff_s   = (bus.op == OP_SUB) ? ~bus.b : bus.b;
        cin_s     = (bus.op == OP_SUB) ? 1'b1 : ((bus.op == OP_ADC) ? carry_q : 1'b0);
        sum_ext_s = {1'b0, bus.a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
        sum_s     = sum_ext_s[WIDTH-1:0];

`ifdef ARITH_MUL_EN
        prod_d  = prod_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;

        step_sum_s  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
        step_prod_s = {step_sum_s, prod_q[WIDTH-1:1]};
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MUL) begin
`ifdef ARITH_MUL_EN
                        mcand_d = bus.a;
                        prod_d  = {{WIDTH{1'b0}}, bus.b};
                        cnt_d   = {CNT_W{1'b0}};
                        busy_d  = 1'b1;
                        state_d = S_MUL;
`else
                        // No multiplier: complete at once with everything cleared.
                        result_d    = {WIDTH{1'b0}};
                        result_hi_d = {WIDTH{1'b0}};
                        overflow_d  = 1'b0;
                        carry_d     = 1'b0;
                        zero_d      = 1'b0;
                        negative_d  = 1'b0;
                        done_d      = 1'b1;
`endif
                    end else begin
                        result_d    = sum_s;
                        result_hi_d = {WIDTH{1'b0}};
                        carry_d     = sum_ext_s[WIDTH];
                        overflow_d  = (bus.a[WIDTH-1] == b_eff_s[WIDTH-1])
                                   && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
                        zero_d      = (sum_s == {WIDTH{1'b0}});
                        negative_d  = sum_s[WIDTH-1];
                        done_d      = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
`ifdef ARITH_MUL_EN
                prod_d = step_prod_s;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    result_hi_d = step_prod_s[2*WIDTH-1:WIDTH];
                    result_d    = step_prod_s[WIDTH-1:0];
                    carry_d     = (step_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
                    overflow_d  = (step_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
                    zero_d      = (step_prod_s == {(2*WIDTH){1'b0}});
                    negative_d  = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            result_hi_q <= {WIDTH{1'b0}};
            overflow_q  <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
`ifdef ARITH_MUL_EN
            prod_q      <= {(2*WIDTH){1'b0}};
            mcand_q     <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            overflow_q  <= overflow_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
`ifdef ARITH_MUL_EN
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.overflow  = overflow_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
endmodule

// File: tb/tb_arith_unit.sv
// tb_arith_unit - directed, table-driven check of arith_unit (WIDTH = 8),
// plus hand-written sequences for reset, the multiplier (or its absence
// when ARITH_MUL_EN is undefined) and ADC carry chaining.
module tb_arith_unit;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    arith_unit_if #(.WIDTH(8)) bus ();

    arith_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flags; // {overflow, carry, zero, negative}
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.overflow, bus.carry, bus.zero, bus.negative};
    endfunction

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    initial begin
        int done_at;
        int busy_cnt;

        total = 0;
        bad   = 0;

        //           op     a      b      res    {ov,c,z,n}
        vecs[0] = '{2'b00, 8'h7F, 8'h01, 8'h80, 4'b1001};
        vecs[1] = '{2'b01, 8'h00, 8'h01, 8'hFF, 4'b0001};
        vecs[2] = '{2'b01, 8'h80, 8'h01, 8'h7F, 4'b1100};
        vecs[3] = '{2'b00, 8'hFF, 8'h01, 8'h00, 4'b0110};
        vecs[4] = '{2'b11, 8'h00, 8'h00, 8'h01, 4'b0000};
        vecs[5] = '{2'b11, 8'h10, 8'h20, 8'h30, 4'b0000};
        vecs[6] = '{2'b01, 8'h05, 8'h05, 8'h00, 4'b0110};
        vecs[7] = '{2'b11, 8'h01, 8'h02, 8'h04, 4'b0000};
        vecs[8] = '{2'b00, 8'h80, 8'h80, 8'h00, 4'b1110};
        vecs[9] = '{2'b11, 8'h7F, 8'h00, 8'h80, 4'b1001};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        repeat (3) tick();

        chk("reset_result", {24'h0, bus.result_hi, bus.result}, 32'h0);
        chk("reset_status", {26'h0, bus.busy, bus.done, flags_now()}, 32'h0);

        rst_n = 1'b1;
        tick();

        // Back-to-back ADD-class ops: done must stay high every cycle.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            chk($sformatf("vec%0d_done", i), {31'h0, bus.done}, 32'h1);
            chk($sformatf("vec%0d_result", i), {24'h0, bus.result}, {24'h0, vecs[i].res});
            chk($sformatf("vec%0d_hi", i), {24'h0, bus.result_hi}, 32'h0);
            chk($sformatf("vec%0d_flags", i), {28'h0, flags_now()}, {28'h0, vecs[i].flags});
        end
        bus.start = 1'b0;
        tick();
        chk("idle_done_low", {31'h0, bus.done}, 32'h0);
        chk("idle_result_held", {24'h0, bus.result}, 32'h80);

`ifdef ARITH_MUL_EN
        // MUL 0xFF x 0xFF with an ADD start attempted while busy.
        issue(2'b10, 8'hFF, 8'hFF);
        tick();
        chk("mul_busy_first", {30'h0, bus.busy, bus.done}, 32'h2);
        issue(2'b00, 8'h01, 8'h01);
        busy_cnt = 1;
        done_at  = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            bus.start = 1'b0;
            if (bus.done) begin
                done_at = i;
                break;
            end else if (bus.busy) begin
                busy_cnt++;
            end
        end
        chk("mul_done_edge", done_at, 8);
        chk("mul_busy_cycles", busy_cnt, 8);
        chk("mul_product", {16'h0, bus.result_hi, bus.result}, 32'hFE01);
        chk("mul_flags", {27'h0, bus.busy, flags_now()}, {27'h0, 1'b0, 4'b1100});
        tick();
        chk("mul_done_pulse", {31'h0, bus.done}, 32'h0);
        chk("mul_held", {16'h0, bus.result_hi, bus.result}, 32'hFE01);

        // Reset on the 4th multiply step aborts with no done.
        issue(2'b10, 8'h02, 8'h03);
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        chk("abort_busy_before", {31'h0, bus.busy}, 32'h1);
        rst_n = 1'b0;
        tick();
        chk("abort_result", {16'h0, bus.result_hi, bus.result}, 32'h0);
        chk("abort_status", {26'h0, bus.busy, bus.done, flags_now()}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("abort_no_done", {30'h0, bus.busy, bus.done}, 32'h0);
`else
        // Without the multiplier MUL completes in one cycle and clears carry.
        issue(2'b00, 8'hFF, 8'h01);
        tick();
        chk("nomul_pre_carry", {31'h0, bus.carry}, 32'h1);
        issue(2'b10, 8'h03, 8'h04);
        tick();
        chk("nomul_done", {30'h0, bus.busy, bus.done}, 32'h1);
        chk("nomul_result", {16'h0, bus.result_hi, bus.result}, 32'h0);
        chk("nomul_flags", {28'h0, flags_now()}, 32'h0);
        issue(2'b11, 8'h00, 8'h00);
        tick();
        chk("nomul_adc_result", {24'h0, bus.result}, 32'h0);
        chk("nomul_adc_flags", {28'h0, flags_now()}, 32'h2);
        bus.start = 1'b0;
        tick();
        chk("nomul_idle", {30'h0, bus.busy, bus.done}, 32'h0);
`endif

        issue(2'b00, 8'h02, 8'h03);
        tick();
        chk("post_add_done", {31'h0, bus.done}, 32'h1);
        chk("post_add_result", {16'h0, bus.result_hi, bus.result}, 32'h05);
        chk("post_add_flags", {28'h0, flags_now()}, 32'h0);
        bus.start = 1'b0;
        tick();
        chk("post_add_idle", {31'h0, bus.done}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
